// File: rtl/ts_update_sched_pkg.sv
// ----------------------------------------------------------------------------
// ts_update_sched_pkg
// Shared definitions for the TS update scheduler:
//   - sched_state_t : scheduler FSM states
//   - ts_info field positions (state in [7:4], substate in [3:0])
//   - DEF_NUM_LANES : default number of ts_gen/tsa lane pairs
// ----------------------------------------------------------------------------
package ts_update_sched_pkg;

    localparam int DEF_NUM_LANES = 4;

    // ts_info layout broadcast to every ts_gen/tsa instance
    localparam int INFO_W         = 8;
    localparam int INFO_STATE_MSB = 7;
    localparam int INFO_STATE_LSB = 4;
    localparam int INFO_SUB_MSB   = 3;
    localparam int INFO_SUB_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/ts_update_sched_ack_collect.sv
// ----------------------------------------------------------------------------
// ts_ack_collect
// Per-lane sticky ack collector. Each masked lane owns a tx and an rx sticky
// bit; an ack pulse sets its bit until the next clear.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : zero all sticky bits this cycle (start of an attempt)
//   mask       : lanes taking part; acks of other lanes are ignored
//   ack_tx     : per-lane ack from ts_gen
//   ack_rx     : per-lane ack from tsa
//   all_acked  : every masked lane has both acks, counting this cycle's acks
//   missing    : masked lanes still lacking an ack, counting this cycle's acks
// ----------------------------------------------------------------------------
module ts_ack_collect
    import ts_update_sched_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [NUM_LANES-1:0] mask,
    input  logic [NUM_LANES-1:0] ack_tx,
    input  logic [NUM_LANES-1:0] ack_rx,
    output logic                 all_acked,
    output logic [NUM_LANES-1:0] missing
);

    logic [NUM_LANES-1:0] got_tx;
    logic [NUM_LANES-1:0] got_rx;
    logic [NUM_LANES-1:0] got_tx_nxt;
    logic [NUM_LANES-1:0] got_rx_nxt;

    // Next sticky values include the current-cycle acks so completion is seen
    // in the same cycle the last ack arrives.
    assign got_tx_nxt = got_tx | (ack_tx & mask);
    assign got_rx_nxt = got_rx | (ack_rx & mask);

    assign missing   = mask & ~(got_tx_nxt & got_rx_nxt);
    assign all_acked = ~|missing;

    // NOTE: sequential state uses non-blocking assignments only; the sticky
    // bits are reset explicitly because a stale ack must never complete an update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            got_tx <= '0;
            got_rx <= '0;
        end else if (clear) begin
            got_tx <= '0;
            got_rx <= '0;
        end else begin
            got_tx <= got_tx_nxt;
            got_rx <= got_rx_nxt;
        end
    end

endmodule

// File: rtl/ts_update_sched.sv
// ----------------------------------------------------------------------------
// ts_update_sched
// Broadcasts a TS update (state/substate) to all lane ts_gen/tsa instances and
// waits until every participating lane has acknowledged on both tx and rx.
//
// Ports
//   clk, rst            : clock, synchronous active-low reset
//   upd_req_valid/ready : request handshake from the core FSM
//   upd_req_info        : state [7:4], substate [3:0] to broadcast
//   lane_mask           : participating lanes, sampled at accept
//   ts_info             : latched info, changes only on accept
//   ts_update           : strobe, high while an attempt is outstanding
//   ts_update_ack_tx/rx : per-lane acks from ts_gen / tsa
//   upd_done            : one-cycle pulse, all masked lanes acked
//   upd_fail            : one-cycle pulse, retries exhausted
//   fail_lanes          : masked lanes missing an ack, held until next accept
//   busy                : scheduler not idle
//
// Configuration
//   TS_UPD_TIMEOUT_EN : when defined, builds the per-attempt timeout, retry and
//                       FAIL path. Otherwise WAIT holds until completion and
//                       upd_fail/fail_lanes are constant zero.
// ----------------------------------------------------------------------------
module ts_update_sched
    import ts_update_sched_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_req_valid,
    output logic                 upd_req_ready,
    input  logic [INFO_W-1:0]    upd_req_info,
    input  logic [NUM_LANES-1:0] lane_mask,
    output logic [INFO_W-1:0]    ts_info,
    output logic                 ts_update,
    input  logic [NUM_LANES-1:0] ts_update_ack_tx,
    input  logic [NUM_LANES-1:0] ts_update_ack_rx,
    output logic                 upd_done,
    output logic                 upd_fail,
    output logic [NUM_LANES-1:0] fail_lanes,
    output logic                 busy
);

    sched_state_t         state;
    logic [NUM_LANES-1:0] mask_q;
    logic                 accept;
    logic                 all_acked;
    logic [NUM_LANES-1:0] missing;
    logic                 timeout_hit;
    logic                 retry_left;
    logic                 attempt_expired;

    assign upd_req_ready   = (state == ST_IDLE);
    assign busy            = (state != ST_IDLE);
    assign accept          = upd_req_valid & upd_req_ready;
    // Completion has priority over a timeout landing in the same cycle.
    assign attempt_expired = (state == ST_WAIT) & ~all_acked & timeout_hit;

    ts_ack_collect #(
        .NUM_LANES (NUM_LANES)
    ) u_ack_collect (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_ISSUE),
        .mask      (mask_q),
        .ack_tx    (ts_update_ack_tx),
        .ack_rx    (ts_update_ack_rx),
        .all_acked (all_acked),
        .missing   (missing)
    );

`ifdef TS_UPD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0] RETRY_LIMIT = RT_W'(MAX_RETRY);

    logic [TO_W-1:0]      to_cnt;
    logic [RT_W-1:0]      retry_cnt;
    logic                 upd_fail_q;
    logic [NUM_LANES-1:0] fail_lanes_q;

    assign timeout_hit = (to_cnt == TO_LAST);
    assign retry_left  = (retry_cnt < RETRY_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt       <= '0;
            retry_cnt    <= '0;
            upd_fail_q   <= 1'b0;
            fail_lanes_q <= '0;
        end else begin
            upd_fail_q <= attempt_expired & ~retry_left;

            // Each attempt gets a fresh WAIT window of TIMEOUT_CYC cycles.
            if (state == ST_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (accept) begin
                retry_cnt <= '0;
            end else if (attempt_expired & retry_left) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            if (accept) begin
                fail_lanes_q <= '0;
            end else if (attempt_expired & ~retry_left) begin
                fail_lanes_q <= missing;
            end
        end
    end

    assign upd_fail   = upd_fail_q;
    assign fail_lanes = fail_lanes_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign retry_left  = 1'b0;
    assign upd_fail    = 1'b0;
    assign fail_lanes  = '0;
    assign unused_cfg  = ^{missing, TIMEOUT_CYC, MAX_RETRY};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ts_info   <= '0;
            mask_q    <= '0;
            ts_update <= 1'b0;
            upd_done  <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ts_info   <= upd_req_info;
                        mask_q    <= lane_mask;
                        ts_update <= |lane_mask;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // An empty mask has nothing to broadcast: the strobe stays
                    // low and the request completes without a WAIT phase.
                    if (~|mask_q) begin
                        upd_done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        // Re-raises the strobe after a retry's one-cycle drop.
                        ts_update <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (all_acked) begin
                        ts_update <= 1'b0;
                        upd_done  <= 1'b1;
                        state     <= ST_DONE;
                    end else if (attempt_expired) begin
                        ts_update <= 1'b0;
                        state     <= retry_left ? ST_ISSUE : ST_FAIL;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_FAIL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_update_sched.sv
// ----------------------------------------------------------------------------
// tb_ts_update_sched
// Self-checking bench for ts_update_sched. Expected completions are queued when
// a request is driven and compared when upd_done/upd_fail pulses: kind, info,
// cycles from accept, number of ts_update-high cycles, number of strobe rises
// and fail_lanes.
// ----------------------------------------------------------------------------
module tb_ts_update_sched;

    localparam int NL = 4;
    localparam int TO = 16;
    localparam int MR = 2;

    logic          clk;
    logic          rst;
    logic          upd_req_valid;
    logic          upd_req_ready;
    logic [7:0]    upd_req_info;
    logic [NL-1:0] lane_mask;
    logic [7:0]    ts_info;
    logic          ts_update;
    logic [NL-1:0] ts_update_ack_tx;
    logic [NL-1:0] ts_update_ack_rx;
    logic          upd_done;
    logic          upd_fail;
    logic [NL-1:0] fail_lanes;
    logic          busy;

    ts_update_sched #(
        .NUM_LANES   (NL),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .upd_req_valid    (upd_req_valid),
        .upd_req_ready    (upd_req_ready),
        .upd_req_info     (upd_req_info),
        .lane_mask        (lane_mask),
        .ts_info          (ts_info),
        .ts_update        (ts_update),
        .ts_update_ack_tx (ts_update_ack_tx),
        .ts_update_ack_rx (ts_update_ack_rx),
        .upd_done         (upd_done),
        .upd_fail         (upd_fail),
        .fail_lanes       (fail_lanes),
        .busy             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit            is_fail;
        logic [NL-1:0] lanes;
        logic [7:0]    info;
        int            lat;
        int            hi;
        int            rises;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit f, input logic [NL-1:0] lanes, input logic [7:0] info,
                            input int lat, input int hi, input int rises);
        exp_t e;
        e.is_fail = f;
        e.lanes   = lanes;
        e.info    = info;
        e.lat     = lat;
        e.hi      = hi;
        e.rises   = rises;
        sb_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, tracks each accepted request and
    // scores it when the completion pulse appears.
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   hi_cnt   = 0;
    int   rise_cnt = 0;
    logic prev_ts  = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst && upd_req_valid && upd_req_ready) begin
                acc_cyc  = cyc;
                hi_cnt   = 0;
                rise_cnt = 0;
            end else begin
                if (ts_update) hi_cnt++;
                if (ts_update && !prev_ts) rise_cnt++;
            end
            prev_ts = ts_update;
            if (upd_done || upd_fail) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, upd_fail, upd_done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_upd_fail",   upd_fail, e.is_fail);
                    check("sb_upd_done",   upd_done, !e.is_fail);
                    check("sb_ts_info",    ts_info, e.info);
                    check("sb_latency",    cyc - acc_cyc, e.lat);
                    check("sb_ts_hi_cyc",  hi_cnt, e.hi);
                    check("sb_ts_rises",   rise_cnt, e.rises);
                    check("sb_fail_lanes", fail_lanes, e.lanes);
                end
            end
        end
    end

    // Drives a request and returns 1 time unit after the accepting edge.
    task automatic start_req(input logic [7:0] info, input logic [NL-1:0] mask);
        int n = 0;
        upd_req_valid = 1'b1;
        upd_req_info  = info;
        lane_mask     = mask;
        @(negedge clk);
        while (!upd_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_req_ready) check("accept_ready", upd_req_ready, 1);
        @(posedge clk);
        #1;
        upd_req_valid = 1'b0;
    endtask

    // Waits n rising edges, then drives the acks for exactly one cycle.
    task automatic pulse_ack(input int n, input logic [NL-1:0] tx, input logic [NL-1:0] rx);
        repeat (n) @(posedge clk);
        #1;
        ts_update_ack_tx = tx;
        ts_update_ack_rx = rx;
        @(posedge clk);
        #1;
        ts_update_ack_tx = '0;
        ts_update_ack_rx = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst              = 1'b0;
        upd_req_valid    = 1'b0;
        upd_req_info     = '0;
        lane_mask        = '0;
        ts_update_ack_tx = '0;
        ts_update_ack_rx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ts_info",    ts_info, 0);
        check("rst_ts_update",  ts_update, 0);
        check("rst_upd_done",   upd_done, 0);
        check("rst_upd_fail",   upd_fail, 0);
        check("rst_fail_lanes", fail_lanes, 0);
        check("rst_busy",       busy, 0);
        check("rst_ready",      upd_req_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All four lanes ack together in WAIT cycle 5 (counting from 0).
        push_exp(0, 4'b0000, 8'h21, 8, 7, 1);
        start_req(8'h21, 4'b1111);
        pulse_ack(6, 4'b1111, 4'b1111);
        wait_idle();

        // Two lanes, acks split over two cycles; lanes 2/3 never ack.
        push_exp(0, 4'b0000, 8'h12, 6, 5, 1);
        start_req(8'h12, 4'b0011);
        pulse_ack(2, 4'b0001, 4'b0010);
        pulse_ack(1, 4'b0010, 4'b0001);
        wait_idle();

        // Empty mask: done two cycles after accept, no strobe.
        push_exp(0, 4'b0000, 8'h0E, 2, 0, 0);
        start_req(8'h0E, 4'b0000);
        wait_idle();

        // Request held valid while busy with new info.
        push_exp(0, 4'b0000, 8'h33, 5, 4, 1);
        push_exp(0, 4'b0000, 8'h44, 4, 3, 1);
        upd_req_valid = 1'b1;
        upd_req_info  = 8'h33;
        lane_mask     = 4'b1111;
        @(negedge clk);
        check("hold_ready_idle", upd_req_ready, 1);
        @(posedge clk);
        #1;
        upd_req_info = 8'h44;
        @(negedge clk);
        check("hold_ready_issue", upd_req_ready, 0);
        check("hold_busy_issue",  busy, 1);
        check("hold_info_issue",  ts_info, 8'h33);
        pulse_ack(3, 4'b1111, 4'b1111);
        @(negedge clk);
        check("hold_ready_done",  upd_req_ready, 0);
        check("hold_info_done",   ts_info, 8'h33);
        @(negedge clk);
        check("hold_ready_again", upd_req_ready, 1);
        @(posedge clk);
        #1;
        upd_req_valid = 1'b0;
        pulse_ack(2, 4'b1111, 4'b1111);
        wait_idle();

`ifdef TS_UPD_TIMEOUT_EN
        // Lane 2 rx never acks: three attempts, then FAIL.
        push_exp(1, 4'b0100, 8'h77, 52, 49, 3);
        start_req(8'h77, 4'b1111);
        ts_update_ack_tx = 4'b1111;
        ts_update_ack_rx = 4'b1011;
        wait_idle();
        ts_update_ack_tx = '0;
        ts_update_ack_rx = '0;
        repeat (3) @(negedge clk);
        check("fail_lanes_hold", fail_lanes, 4'b0100);
        check("fail_pulse_once", upd_fail, 0);
`else
        // Without the timeout, WAIT holds with lane 2 rx missing.
        push_exp(0, 4'b0000, 8'h77, 63, 62, 1);
        start_req(8'h77, 4'b1111);
        ts_update_ack_tx = 4'b1111;
        ts_update_ack_rx = 4'b1011;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("noto_busy",      busy, 1);
        check("noto_ts_update", ts_update, 1);
        check("noto_no_fail",   upd_fail, 0);
        repeat (21) @(posedge clk);
        #1;
        ts_update_ack_rx = 4'b1111;
        @(posedge clk);
        #1;
        ts_update_ack_tx = '0;
        ts_update_ack_rx = '0;
        wait_idle();
`endif

        // fail_lanes clears on the next accept.
        push_exp(0, 4'b0000, 8'h9C, 3, 2, 1);
        start_req(8'h9C, 4'b0101);
        @(negedge clk);
        check("fail_lanes_clear", fail_lanes, 0);
        pulse_ack(1, 4'b0101, 4'b0101);
        wait_idle();

        // Reset in the middle of WAIT aborts silently.
        start_req(8'h5A, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ts_update",  ts_update, 0);
        check("mid_rst_busy",       busy, 0);
        check("mid_rst_ts_info",    ts_info, 0);
        check("mid_rst_upd_done",   upd_done, 0);
        check("mid_rst_upd_fail",   upd_fail, 0);
        check("mid_rst_fail_lanes", fail_lanes, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Normal operation after reset.
        push_exp(0, 4'b0000, 8'hA5, 6, 5, 1);
        start_req(8'hA5, 4'b1000);
        pulse_ack(4, 4'b1000, 4'b1000);
        wait_idle();

        repeat (2) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
